channel_error_injector: RTL
===========================

// Module: channel_error_injector
// PURPOSE
//  Configurable bit-error channel between convolutional encoder and Viterbi decoder in tx/rx benches.
//  Replaces hard-wired word-count error logic with runtime-selectable burst, random and single-shot modes.
//  Generalised symbol width; counts symbols and flipped bits per measurement window.
//  Registered: one symbol in, one (possibly corrupted) symbol out.
// PARAMETERS
//  SYM_W     2        symbol width (encoder output bits per step)
//  CNT_W     16       width of phase/window/statistics counters
//  LFSR_W    16       PRNG width for random mode
//  LFSR_SEED 16'hACE1 PRNG reset/start value (nonzero)
// PORTS
//  clk           in   1       clock
//  rst           in   1       synchronous active-low reset
//  cfg_mode      in   2       0 OFF, 1 BURST, 2 RANDOM, 3 SINGLE
//  cfg_period    in   CNT_W   BURST repeat period / SINGLE start offset, in symbols
//  cfg_burst_len in   CNT_W   consecutive corrupted symbols per burst
//  cfg_thresh    in   LFSR_W  RANDOM: corrupt when lfsr < cfg_thresh
//  cfg_mask      in   SYM_W   bits XORed into a corrupted symbol
//  cfg_window    in   CNT_W   symbols per measurement run; 0 = unlimited
//  start         in   1       1-cycle pulse: latch cfg, clear stats, begin run
//  valid_i       in   1       sym_i valid
//  sym_i         in   SYM_W   encoder symbol
//  valid_o       out  1       sym_o valid, = valid_i delayed 1 cycle
//  sym_o         out  SYM_W   channel output
//  err_o         out  1       sym_o was corrupted
//  busy          out  1       run in progress
//  done          out  1       window complete (sticky)
//  sym_ct        out  CNT_W   valid symbols seen this run
//  bit_err_ct    out  CNT_W   total bits flipped this run (saturating)
// BEHAVIOUR
//  Reset (rst==0 at posedge): state IDLE; all outputs 0; counters 0; lfsr=LFSR_SEED. Mid-run reset aborts the run.
//  FSM IDLE -start-> RUN; RUN -(cfg_window!=0 && sym_ct==cfg_window)-> DONE; DONE -start-> RUN.
//  start in RUN ignored. start in IDLE/DONE: latch all cfg_*, clear sym_ct/bit_err_ct/phase, lfsr=LFSR_SEED.
//  Datapath: on valid_i, next cycle sym_o = sym_i ^ (hit ? mask_q : 0), err_o = hit, valid_o = 1.
//   On !valid_i: valid_o=0, err_o=0, sym_o holds, no counter or lfsr advances.
//  hit is forced 0 in IDLE, DONE, mode OFF, or mask_q==0; outside RUN the block is pure 1-cycle pass-through.
//  Per valid symbol in RUN, with idx = sym_ct before increment:
//   BURST: hit = phase < burst_len_q; phase wraps to 0 after period_q-1 (period_q==0 treated as 1).
//     burst_len_q >= period_q => every symbol hit; burst_len_q==0 => never.
//   RANDOM: hit = lfsr < thresh_q; lfsr advances one step per valid symbol (Galois, taps in pkg).
//   SINGLE: hit = (idx >= period_q) && (idx < period_q + burst_len_q); compare in CNT_W+1 bits, no wrap.
//  sym_ct increments per valid symbol in RUN; final symbol (sym_ct -> cfg_window) is still processed, then DONE.
//  bit_err_ct += popcount(mask_q) on each hit; saturates at all-ones.
//  sym_ct/bit_err_ct hold their values in DONE until next start or reset.
//  busy = (state==RUN); done = (state==DONE). Both registered.
//  Simultaneous start + valid_i in IDLE: that symbol passes uncorrupted and is not counted; run begins next cycle.
//  Unlimited window: sym_ct wraps to 0 at CNT_W overflow; BURST phase is not reset by this wrap.
// STRUCTURE
//  Package chan_err_pkg: mode_e {OFF,BURST,RANDOM,SINGLE}, state_e {IDLE,RUN,DONE},
//   LFSR_TAPS localparam (16-bit: 16'hB400), popcount function.
//  Sub-module lfsr_prng #(W,SEED,TAPS): ports clk, rst, load, step, value.
//  Top: FSM, cfg latch, phase/window counters, hit decode, output register, stats.
// TESTING
//  1 OFF, start, 20 valid symbols 2'b10 -> sym_o=2'b10, err_o=0, bit_err_ct=0, sym_ct=20.
//  2 BURST period=8 len=2 mask=2'b11 window=32 -> hits at idx 0,1,8,9,16,17,24,25; bit_err_ct=16;
//    done rises the cycle after symbol 32, busy drops.
//  3 RANDOM thresh=16'h8000 window=1000 mask=2'b01 -> hit pattern matches reference model of lfsr_prng
//    from SEED exactly; bit_err_ct = number of hits; rerun with start gives identical pattern.
//  4 SINGLE period=5 len=3 mask=2'b10 -> only idx 5,6,7 corrupted (bit1 flipped); valid_i gaps of 3
//    cycles inside the burst do not change which symbols are hit.
//  5 Reset mid-run at sym_ct=10 -> next cycle all outputs 0, state IDLE; new start replays from idx 0.
//  6 CNT_W=4, BURST period=1 len=1 mask=2'b11 window=0 -> bit_err_ct saturates at 4'hF, sym_ct wraps, busy stays 1.

Source files
------------

// File: rtl/channel_error_injector_pkg.sv
// Shared types and helpers for the channel error injector: mode and FSM
// encodings, the PRNG feedback taps, and a popcount used for bit statistics.
package chan_err_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_BURST  = 2'd1,
    MODE_RANDOM = 2'd2,
    MODE_SINGLE = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Galois feedback for the maximal-length x^16+x^14+x^13+x^11+1 polynomial.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/channel_error_injector_lfsr.sv
// Right-shifting Galois LFSR: loadable to SEED, advances one step per step pulse.
module lfsr_prng #(
  parameter int             W    = 16,
  parameter logic [W-1:0]   SEED = W'(16'hACE1),
  parameter logic [W-1:0]   TAPS = W'(16'hB400)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  output logic [W-1:0] value
);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = SEED;
    end else if (step) begin
      value_d = (value_q >> 1) ^ (value_q[0] ? TAPS : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      value_q <= SEED;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/channel_error_injector.sv
// Registered bit-error channel with OFF/BURST/RANDOM/SINGLE corruption modes
// and per-run symbol and flipped-bit statistics over a measurement window.
module channel_error_injector
  import chan_err_pkg::*;
#(
  parameter int                SYM_W     = 2,
  parameter int                CNT_W     = 16,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'(16'hACE1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        cfg_mode,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [CNT_W-1:0]  cfg_burst_len,
  input  logic [LFSR_W-1:0] cfg_thresh,
  input  logic [SYM_W-1:0]  cfg_mask,
  input  logic [CNT_W-1:0]  cfg_window,
  input  logic              start,
  input  logic              valid_i,
  input  logic [SYM_W-1:0]  sym_i,
  output logic              valid_o,
  output logic [SYM_W-1:0]  sym_o,
  output logic              err_o,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  sym_ct,
  output logic [CNT_W-1:0]  bit_err_ct
);

  state_e              state_q, state_d;
  mode_e               mode_q;
  logic [CNT_W-1:0]    period_q, burst_len_q, window_q;
  logic [LFSR_W-1:0]   thresh_q;
  logic [SYM_W-1:0]    mask_q;
  logic [CNT_W-1:0]    phase_q, phase_d;
  logic [CNT_W-1:0]    sym_ct_q, sym_ct_d;
  logic [CNT_W-1:0]    bit_err_ct_q, bit_err_ct_d;
  logic                busy_q, done_q;
  logic                valid_o_q, err_o_q;
  logic [SYM_W-1:0]    sym_o_q;

  logic                launch, count, mode_hit, hit;
  logic [CNT_W-1:0]    eff_period;
  logic [CNT_W:0]      idx_ext, single_lo, single_hi;
  logic [CNT_W:0]      mask_pop, err_sum;
  logic [LFSR_W-1:0]   lfsr_value;

  lfsr_prng #(
    .W    (LFSR_W),
    .SEED (LFSR_SEED),
    .TAPS (LFSR_W'(LFSR_TAPS))
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (launch),
    .step  (count && (mode_q == MODE_RANDOM)),
    .value (lfsr_value)
  );

  assign mask_pop = (CNT_W+1)'(popcount(32'(mask_q)));

  // Hit decode: corruption only ever applies to a valid symbol inside a run.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    mode_hit   = 1'b0;
    launch     = start && (state_q != ST_RUN);
    count      = (state_q == ST_RUN) && valid_i;
    eff_period = (period_q == '0) ? CNT_W'(1) : period_q;
    idx_ext    = {1'b0, sym_ct_q};
    single_lo  = {1'b0, period_q};
    single_hi  = {1'b0, period_q} + {1'b0, burst_len_q};
    case (mode_q)
      MODE_BURST:  mode_hit = (phase_q < burst_len_q);
      MODE_RANDOM: mode_hit = (lfsr_value < thresh_q);
      MODE_SINGLE: mode_hit = (idx_ext >= single_lo) && (idx_ext < single_hi);
      default:     mode_hit = 1'b0;
    endcase
    hit = count && (mask_q != '0) && mode_hit;
  end

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    sym_ct_d     = sym_ct_q;
    bit_err_ct_d = bit_err_ct_q;
    err_sum      = {1'b0, bit_err_ct_q} + mask_pop;
    if (launch) begin
      state_d      = ST_RUN;
      phase_d      = '0;
      sym_ct_d     = '0;
      bit_err_ct_d = '0;
    end else if (count) begin
      sym_ct_d = sym_ct_q + CNT_W'(1);
      phase_d  = (phase_q >= eff_period - CNT_W'(1)) ? '0 : phase_q + CNT_W'(1);
      if (hit) begin
        bit_err_ct_d = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
      end
      // The closing symbol is still processed; the run ends on the same edge.
      if ((window_q != '0) && (sym_ct_d == window_q)) begin
        state_d = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: all state uses non-blocking assignment so every register samples pre-edge values.
    if (!rst) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_OFF;
      period_q     <= '0;
      burst_len_q  <= '0;
      window_q     <= '0;
      thresh_q     <= '0;
      mask_q       <= '0;
      phase_q      <= '0;
      sym_ct_q     <= '0;
      bit_err_ct_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      sym_ct_q     <= sym_ct_d;
      bit_err_ct_q <= bit_err_ct_d;
      busy_q       <= (state_d == ST_RUN);
      done_q       <= (state_d == ST_DONE);
      if (launch) begin
        mode_q      <= mode_e'(cfg_mode);
        period_q    <= cfg_period;
        burst_len_q <= cfg_burst_len;
        window_q    <= cfg_window;
        thresh_q    <= cfg_thresh;
        mask_q      <= cfg_mask;
      end
    end
  end

  // Output stage: sym_o keeps its last value across gaps in valid_i.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_o_q <= 1'b0;
      err_o_q   <= 1'b0;
      sym_o_q   <= '0;
    end else begin
      valid_o_q <= valid_i;
      err_o_q   <= hit;
      if (valid_i) begin
        sym_o_q <= sym_i ^ (hit ? mask_q : '0);
      end
    end
  end

  assign valid_o    = valid_o_q;
  assign err_o      = err_o_q;
  assign sym_o      = sym_o_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign sym_ct     = sym_ct_q;
  assign bit_err_ct = bit_err_ct_q;

endmodule
